// File: rtl/flash_pkg.sv
// flash_pkg: shared encodings for the NAND op sequencer.
// Modes, opcodes, request ops and the instruction word builder.
package flash_pkg;

  localparam logic [3:0] MODE_IDLE = 4'd1;
  localparam logic [3:0] MODE_CMD  = 4'd2;
  localparam logic [3:0] MODE_ADDR = 4'd3;
  localparam logic [3:0] MODE_DIN  = 4'd4;
  localparam logic [3:0] MODE_DOUT = 4'd5;
  localparam logic [3:0] MODE_DEND = 4'd6;

  localparam logic [15:0] INSTR_PFX = 16'hffff;

  localparam logic [7:0] NAND_READ1  = 8'h00;
  localparam logic [7:0] NAND_READ2  = 8'h30;
  localparam logic [7:0] NAND_PROG1  = 8'h80;
  localparam logic [7:0] NAND_PROG2  = 8'h10;
  localparam logic [7:0] NAND_ERASE1 = 8'h60;
  localparam logic [7:0] NAND_ERASE2 = 8'hd0;
  localparam logic [7:0] NAND_RESET  = 8'hff;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RESET = 2'd3;

  function automatic logic [31:0] build_instr(
    input logic [3:0] rpt,
    input logic [3:0] mode
  );
    return {INSTR_PFX, 8'h00, rpt, mode};
  endfunction

endpackage

// File: rtl/flash_op_sequencer_if.sv
// flash_op_sequencer_if: request, payload and FIFO-side signals.
// master is the host/FIFO side, slave is the sequencer.
interface flash_op_sequencer_if #(
  parameter int ROW_W = 24,
  parameter int COL_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [7:0]       pl_data;
  logic             pl_valid;
  logic             pl_ready;
  logic [31:0]      instr;
  logic             instr_wr;
  logic             instr_full;
  logic [7:0]       dout;
  logic             dout_wr;
  logic             dout_full;
  logic             busy;
  logic             op_done;

  modport master (
    output req_valid, req_op, req_row, req_col,
    output pl_data, pl_valid, instr_full, dout_full,
    input  req_ready, pl_ready, instr, instr_wr,
    input  dout, dout_wr, busy, op_done
  );

  modport slave (
    input  req_valid, req_op, req_row, req_col,
    input  pl_data, pl_valid, instr_full, dout_full,
    output req_ready, pl_ready, instr, instr_wr,
    output dout, dout_wr, busy, op_done
  );
endinterface

// File: rtl/flash_seq_emitter.sv
// flash_seq_emitter: registered word/byte write stage.
// A step fires whole or not at all, gated by the FIFO full flags.
module flash_seq_emitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        word_en_i,
  input  logic [31:0] word_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  input  logic        pl_sel_i,
  input  logic [7:0]  pl_data_i,
  input  logic        pl_valid_i,
  input  logic        instr_full_i,
  input  logic        dout_full_i,
  output logic        done_o,
  output logic        pl_ready_o,
  output logic [31:0] instr_o,
  output logic        instr_wr_o,
  output logic [7:0]  dout_o,
  output logic        dout_wr_o
);

  logic        fire;
  logic [31:0] instr_q;
  logic        instr_wr_q;
  logic [7:0]  dout_q;
  logic        dout_wr_q;

  assign fire = req_i
              & ~(word_en_i & instr_full_i)
              & ~(byte_en_i & dout_full_i)
              & ~(pl_sel_i & ~pl_valid_i);

  assign done_o     = fire;
  assign pl_ready_o = fire & pl_sel_i;
  assign instr_o    = instr_q;
  assign instr_wr_o = instr_wr_q;
  assign dout_o     = dout_q;
  assign dout_wr_o  = dout_wr_q;

  // Register the strobes and their data together on a fired step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      instr_wr_q <= 1'b0;
      dout_q     <= '0;
      dout_wr_q  <= 1'b0;
    end else begin
      instr_wr_q <= fire & word_en_i;
      dout_wr_q  <= fire & byte_en_i;
      if (fire & word_en_i)
        instr_q <= word_i;
      if (fire & byte_en_i)
        dout_q <= pl_sel_i ? pl_data_i : byte_i;
    end
  end

endmodule

// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer: expands NAND ops into flash_ctrl
// instruction words plus command/address/payload bytes.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter int PAGE_BYTES = 2048,
  parameter int ROW_W      = 24,
  parameter int COL_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  flash_op_sequencer_if.slave bus
);

  localparam int NGRP = PAGE_BYTES / 16;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD1 = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_CMD2 = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_TAIL = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       acnt_q, acnt_d;
  logic [GW-1:0]    grp_q, grp_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic             dend_q, dend_d;

  logic        is_read, is_prog, is_erase, is_reset;
  logic [23:0] row24;
  logic [15:0] col16;
  logic [2:0]  aidx, alast;
  logic [7:0]  abyte, cmd1, cmd2;
  logic        st_req, st_word, st_byte, st_pl, st_done;
  logic [31:0] st_wval;
  logic [7:0]  st_bval;

  assign is_read  = op_q == OP_READ;
  assign is_prog  = op_q == OP_PROG;
  assign is_erase = op_q == OP_ERASE;
  assign is_reset = op_q == OP_RESET;
  assign row24    = 24'(row_q);
  assign col16    = 16'(col_q);
  assign alast    = is_erase ? 3'd2 : 3'd4;
  assign aidx     = is_erase ? acnt_q + 3'd2 : acnt_q;

  assign bus.req_ready = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.op_done   = state_q == S_DONE;

  // Address bytes: column then row, each LSB first.
  always_comb begin
    abyte = row24[23:16];
    case (aidx)
      3'd0:    abyte = col16[7:0];
      3'd1:    abyte = col16[15:8];
      3'd2:    abyte = row24[7:0];
      3'd3:    abyte = row24[15:8];
      default: abyte = row24[23:16];
    endcase
  end

  // Opening and confirming opcodes of the latched op.
  always_comb begin
    cmd1 = NAND_RESET;
    cmd2 = NAND_READ2;
    unique case (1'b1)
      is_read:  begin cmd1 = NAND_READ1;  cmd2 = NAND_READ2;  end
      is_prog:  begin cmd1 = NAND_PROG1;  cmd2 = NAND_PROG2;  end
      is_erase: begin cmd1 = NAND_ERASE1; cmd2 = NAND_ERASE2; end
      default:  begin cmd1 = NAND_RESET;  cmd2 = NAND_READ2;  end
    endcase
  end

  // Step presented to the emitter; command bytes always
  // travel with a command word so flash_ctrl consumes them.
  always_comb begin
    st_req  = 1'b0;
    st_word = 1'b0;
    st_wval = build_instr(4'd0, MODE_IDLE);
    st_byte = 1'b0;
    st_bval = 8'h00;
    st_pl   = 1'b0;
    case (state_q)
      S_CMD1: begin
        st_req  = 1'b1;
        st_word = 1'b1;
        st_wval = build_instr(4'd0, MODE_CMD);
        st_byte = 1'b1;
        st_bval = cmd1;
      end
      S_ADDR: begin
        st_req  = 1'b1;
        st_word = acnt_q == 3'd0;
        st_wval = build_instr({1'b0, alast}, MODE_ADDR);
        st_byte = 1'b1;
        st_bval = abyte;
      end
      S_CMD2: begin
        st_req  = 1'b1;
        st_word = 1'b1;
        st_wval = build_instr(4'd0, MODE_CMD);
        st_byte = 1'b1;
        st_bval = cmd2;
      end
      S_DATA: begin
        st_req = 1'b1;
        if (is_read) begin
          st_word = 1'b1;
          st_wval = build_instr(4'd15, MODE_DOUT);
        end else begin
          st_word = bcnt_q == 4'd0;
          st_wval = build_instr(4'd15, MODE_DIN);
          st_byte = 1'b1;
          st_pl   = 1'b1;
        end
      end
      S_TAIL: begin
        st_req  = 1'b1;
        st_word = 1'b1;
        st_wval = dend_q ? build_instr(4'd0, MODE_DEND)
                         : build_instr(4'd0, MODE_IDLE);
      end
      default: st_req = 1'b0;
    endcase
  end

  // Sequencing: advance on each completed step.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    row_d   = row_q;
    col_d   = col_q;
    acnt_d  = acnt_q;
    grp_d   = grp_q;
    bcnt_d  = bcnt_q;
    dend_d  = dend_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        state_d = S_CMD1;
        op_d    = bus.req_op;
        row_d   = bus.req_row;
        col_d   = bus.req_col;
        acnt_d  = '0;
        grp_d   = '0;
        bcnt_d  = '0;
        dend_d  = 1'b0;
      end
      S_CMD1: if (st_done)
        state_d = is_reset ? S_TAIL : S_ADDR;
      S_ADDR: if (st_done) begin
        acnt_d = acnt_q + 3'd1;
        if (acnt_q == alast) begin
          acnt_d  = '0;
          state_d = is_prog ? S_DATA : S_CMD2;
        end
      end
      S_CMD2: if (st_done)
        state_d = S_TAIL;
      S_TAIL: if (st_done)
        state_d = (is_read & ~dend_q) ? S_DATA : S_DONE;
      S_DATA: if (st_done) begin
        if (is_read) begin
          grp_d = grp_q + 1'b1;
          if (grp_q == GRP_LAST) begin
            state_d = S_TAIL;
            dend_d  = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd15) begin
            grp_d = grp_q + 1'b1;
            if (grp_q == GRP_LAST)
              state_d = S_CMD2;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      row_q   <= '0;
      col_q   <= '0;
      acnt_q  <= '0;
      grp_q   <= '0;
      bcnt_q  <= '0;
      dend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acnt_q  <= acnt_d;
      grp_q   <= grp_d;
      bcnt_q  <= bcnt_d;
      dend_q  <= dend_d;
    end
  end

  flash_seq_emitter u_emit (
    .clk          (clk),
    .rst          (rst),
    .req_i        (st_req),
    .word_en_i    (st_word),
    .word_i       (st_wval),
    .byte_en_i    (st_byte),
    .byte_i       (st_bval),
    .pl_sel_i     (st_pl),
    .pl_data_i    (bus.pl_data),
    .pl_valid_i   (bus.pl_valid),
    .instr_full_i (bus.instr_full),
    .dout_full_i  (bus.dout_full),
    .done_o       (st_done),
    .pl_ready_o   (bus.pl_ready),
    .instr_o      (bus.instr),
    .instr_wr_o   (bus.instr_wr),
    .dout_o       (bus.dout),
    .dout_wr_o    (bus.dout_wr)
  );

endmodule

// File: tb/tb_flash_op_sequencer.sv
// tb_flash_op_sequencer: scoreboard bench for the op sequencer.
// Big DUT uses 2048-byte pages, small DUT 32-byte pages.
`timescale 1ns/1ps
module tb_flash_op_sequencer;
  import flash_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [23:0] req_row = '0;
  logic [15:0] req_col = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b1;
  logic        instr_full = 1'b0;
  logic        dout_full = 1'b0;

  flash_op_sequencer_if #(.ROW_W(24), .COL_W(16)) bb();
  flash_op_sequencer_if #(.ROW_W(24), .COL_W(16)) sb();

  assign bb.req_valid  = req_valid & ~sel;
  assign sb.req_valid  = req_valid & sel;
  assign bb.req_op     = req_op;
  assign sb.req_op     = req_op;
  assign bb.req_row    = req_row;
  assign sb.req_row    = req_row;
  assign bb.req_col    = req_col;
  assign sb.req_col    = req_col;
  assign bb.pl_data    = pl_data;
  assign sb.pl_data    = pl_data;
  assign bb.pl_valid   = pl_valid;
  assign sb.pl_valid   = pl_valid;
  assign bb.instr_full = instr_full;
  assign sb.instr_full = instr_full;
  assign bb.dout_full  = dout_full;
  assign sb.dout_full  = dout_full;

  flash_op_sequencer #(.PAGE_BYTES(2048), .ROW_W(24), .COL_W(16))
    u_big (.clk(clk), .rst(rst), .bus(bb));
  flash_op_sequencer #(.PAGE_BYTES(32), .ROW_W(24), .COL_W(16))
    u_small (.clk(clk), .rst(rst), .bus(sb));

  logic        m_iwr, m_dwr, m_rdy, m_busy, m_done, m_plr;
  logic [31:0] m_instr;
  logic [7:0]  m_dout;
  assign m_iwr   = sel ? sb.instr_wr  : bb.instr_wr;
  assign m_dwr   = sel ? sb.dout_wr   : bb.dout_wr;
  assign m_rdy   = sel ? sb.req_ready : bb.req_ready;
  assign m_busy  = sel ? sb.busy      : bb.busy;
  assign m_done  = sel ? sb.op_done   : bb.op_done;
  assign m_plr   = sel ? sb.pl_ready  : bb.pl_ready;
  assign m_instr = sel ? sb.instr     : bb.instr;
  assign m_dout  = sel ? sb.dout      : bb.dout;

  logic [31:0] exp_i[$];
  logic [7:0]  exp_d[$];
  int nchk = 0;
  int nerr = 0;
  int ndone = 0;
  int ndwr = 0;
  int nf4 = 0;
  int pidx = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare each write against the expected stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_iwr) begin
        if (exp_i.size() == 0) chk("instr_extra", m_instr, 32'h0);
        else chk("instr", m_instr, exp_i.pop_front());
        if (m_instr == 32'hffff00f4) begin
          chk("f4_pair", {23'h0, m_dwr, m_dout},
              {23'h0, 1'b1, 8'(nf4 * 16)});
          nf4++;
        end
      end
      if (m_dwr) begin
        if (exp_d.size() == 0) chk("dout_extra", {24'h0, m_dout}, 32'h100);
        else chk("dout", {24'h0, m_dout}, {24'h0, exp_d.pop_front()});
        ndwr++;
      end
      if (m_done) ndone++;
    end
  end

  task automatic push_addr(input logic [23:0] row, input logic [15:0] col);
    exp_d.push_back(col[7:0]);
    exp_d.push_back(col[15:8]);
    exp_d.push_back(row[7:0]);
    exp_d.push_back(row[15:8]);
    exp_d.push_back(row[23:16]);
  endtask

  task automatic push_op(input logic [1:0] op, input logic [23:0] row,
                         input logic [15:0] col, input int pbytes);
    exp_i.push_back(32'hffff0002);
    case (op)
      OP_READ: begin
        exp_d.push_back(8'h00);
        exp_i.push_back(32'hffff0043);
        push_addr(row, col);
        exp_i.push_back(32'hffff0002);
        exp_d.push_back(8'h30);
        exp_i.push_back(32'hffff0001);
        for (int g = 0; g < pbytes / 16; g++) exp_i.push_back(32'hffff00f5);
        exp_i.push_back(32'hffff0006);
      end
      OP_PROG: begin
        exp_d.push_back(8'h80);
        exp_i.push_back(32'hffff0043);
        push_addr(row, col);
        for (int g = 0; g < pbytes / 16; g++) exp_i.push_back(32'hffff00f4);
        for (int b = 0; b < pbytes; b++) exp_d.push_back(8'(b));
        exp_i.push_back(32'hffff0002);
        exp_d.push_back(8'h10);
        exp_i.push_back(32'hffff0001);
      end
      OP_ERASE: begin
        exp_d.push_back(8'h60);
        exp_i.push_back(32'hffff0023);
        exp_d.push_back(row[7:0]);
        exp_d.push_back(row[15:8]);
        exp_d.push_back(row[23:16]);
        exp_i.push_back(32'hffff0002);
        exp_d.push_back(8'hd0);
        exp_i.push_back(32'hffff0001);
      end
      default: begin
        exp_d.push_back(8'hff);
        exp_i.push_back(32'hffff0001);
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [23:0] row,
                       input logic [15:0] col);
    int t = 0;
    @(posedge clk); #1;
    req_op = op; req_row = row; req_col = col; req_valid = 1'b1;
    @(negedge clk);
    while (!m_rdy && t < 50) begin @(negedge clk); t++; end
    chk("accept", {31'h0, m_rdy}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_row = ~row; req_col = ~col; req_op = ~op;
  endtask

  // Runs until op_done, toggling payload valid every third cycle.
  task automatic wait_done(input int d0, input int budget);
    int t = 0;
    logic take;
    do begin
      @(negedge clk); t++;
      chk("rdy_busy", {30'h0, m_rdy, m_busy}, 32'h1);
      take = pl_valid & m_plr;
      if (!pl_valid) chk("pl_gap", {31'h0, m_plr}, 32'h0);
      if (m_done) break;
      @(posedge clk); #1;
      if (take) pidx++;
      pl_data = 8'(pidx);
      pl_valid = (t % 3) != 2;
    end while (t < budget);
    chk("done_seen", {31'h0, m_done}, 32'h1);
    @(negedge clk);
    chk("post_done", {29'h0, m_done, m_rdy, m_busy}, 32'h2);
    chk("ndone", ndone - d0, 1);
    chk("q_empty", exp_i.size() + exp_d.size(), 0);
    pl_valid = 1'b1;
  endtask

  initial begin
    int d0, base, t;
    @(negedge clk);
    chk("rst_out", {26'h0, m_iwr, m_dwr, m_busy, m_done, m_rdy, m_plr},
        32'h2);
    chk("rst_instr", m_instr, 32'h0);
    chk("rst_dout", {24'h0, m_dout}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // READ on a 2048-byte page
    d0 = ndone;
    push_op(OP_READ, 24'h123456, 16'h0010, 2048);
    issue(OP_READ, 24'h123456, 16'h0010);
    wait_done(d0, 400);

    // PROGRAM on a 32-byte page with gappy payload
    sel = 1'b1; pidx = 0; nf4 = 0; pl_data = 8'h00;
    d0 = ndone;
    push_op(OP_PROG, 24'h010203, 16'h0040, 32);
    issue(OP_PROG, 24'h010203, 16'h0040);
    wait_done(d0, 200);
    chk("nf4", nf4, 2);
    chk("pl_count", pidx, 32);
    @(posedge clk); #1; sel = 1'b0;

    // ERASE with dout_full held mid-address
    d0 = ndone; base = ndwr;
    push_op(OP_ERASE, 24'habcdef, 16'h0000, 0);
    issue(OP_ERASE, 24'habcdef, 16'h5555);
    t = 0;
    while (ndwr < base + 2 && t < 20) begin @(negedge clk); #1; t++; end
    chk("erase_pre", ndwr - base, 2);
    @(posedge clk); #1; dout_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) chk("dfull_hold", {31'h0, m_dwr}, 32'h0);
      chk("dfull_busy", {31'h0, m_busy}, 32'h1);
    end
    @(posedge clk); #1; dout_full = 1'b0;
    wait_done(d0, 50);

    // instr_full blocks the paired CMD1 word and byte
    instr_full = 1'b1;
    d0 = ndone;
    push_op(OP_RESET, 24'h0, 16'h0, 0);
    issue(OP_RESET, 24'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ifull_hold", {30'h0, m_iwr, m_dwr}, 32'h0);
    end
    @(posedge clk); #1; instr_full = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(m_iwr | m_dwr) && t < 5);
    chk("pair_fire", {30'h0, m_iwr, m_dwr}, 32'h3);
    wait_done(d0, 20);

    // RESET then READ with req_valid held high
    d0 = ndone;
    push_op(OP_RESET, 24'h0, 16'h0, 0);
    @(posedge clk); #1;
    req_op = OP_RESET; req_row = 24'h0; req_col = 16'h0; req_valid = 1'b1;
    @(negedge clk);
    chk("rst_acc", {31'h0, m_rdy}, 32'h1);
    @(posedge clk); #1;
    req_op = OP_READ; req_row = 24'h000777; req_col = 16'h0020;
    push_op(OP_READ, 24'h000777, 16'h0020, 2048);
    t = 0;
    do begin @(negedge clk); t++; end while (!m_done && t < 20);
    chk("rst_done", {31'h0, m_done}, 32'h1);
    @(negedge clk);
    chk("idle_rdy", {30'h0, m_rdy, m_busy}, 32'h2);
    chk("ndone_r", ndone - d0, 1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("held_acc", {30'h0, m_rdy, m_busy}, 32'h1);
    wait_done(d0 + 1, 400);

    // rst during the READ data phase, then a clean READ
    d0 = ndone;
    push_op(OP_READ, 24'h00beef, 16'h0001, 2048);
    issue(OP_READ, 24'h00beef, 16'h0001);
    repeat (20) @(negedge clk);
    chk("in_data", m_instr, 32'hffff00f5);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_out", {27'h0, m_iwr, m_dwr, m_busy, m_rdy, m_done},
        32'h2);
    exp_i.delete(); exp_d.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", {29'h0, m_iwr, m_busy, m_rdy}, 32'h1);
    chk("abort_nodone", ndone - d0, 0);
    d0 = ndone;
    push_op(OP_READ, 24'h123456, 16'h0010, 2048);
    issue(OP_READ, 24'h123456, 16'h0010);
    wait_done(d0, 400);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
